// File: rtl/conv_loop_sequencer.sv
// conv_loop_sequencer
// Control FSM for a 3-tap MAC datapath (mac3 plus a/b operand registers) running a
// KxK convolution layer. Loop nest, outermost first: y, x, co, ci, ky. Each kernel row
// costs one operand FETCH and one MAC. Each (y, x, co, ci) step ends in one WRITE,
// which read-modify-writes the partial sum held in external memory.
module conv_loop_sequencer #(
  parameter int LOG2_OF_MEM_HEIGHT = 20,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int OUTPUT_NB_CHANNELS = 64,
  // One mac3 operation consumes one kernel row, so this must stay 3.
  parameter int KERNEL_SIZE        = 3,
  // Counter widths. Each is held at 1 bit or more so that an extent of 1 still elaborates.
  localparam int XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
  localparam int YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
  localparam int COW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1,
  localparam int CIW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1,
  localparam int KW  = (KERNEL_SIZE        > 1) ? $clog2(KERNEL_SIZE)        : 1,
  localparam int AW  = LOG2_OF_MEM_HEIGHT
) (
  input  logic           clk,
  input  logic           rst_in,
  input  logic           start,
  output logic           running,
  input  logic           a_valid,
  input  logic           b_valid,
  output logic           a_ready,
  output logic           b_ready,
  output logic           write_a,
  output logic           write_b,
  output logic           mac_valid,
  output logic           mac_accumulate_internal,
  output logic           mac_accumulate_with_0,
  output logic           mem_re,
  output logic [AW-1:0]  mem_read_addr,
  output logic           mem_we,
  output logic [AW-1:0]  mem_write_addr,
  output logic           output_valid,
  output logic [XW-1:0]  output_x,
  output logic [YW-1:0]  output_y,
  output logic [COW-1:0] output_ch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MAC   = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [YW-1:0]  y;
  logic [XW-1:0]  x;
  logic [COW-1:0] co;
  logic [CIW-1:0] ci;
  logic [KW-1:0]  ky;

  logic y_last, x_last, co_last, ci_last, ky_last;
  logic layer_done;
  logic transfer;
  logic [AW-1:0] addr;

  // Wrap points of each loop counter, and the point where the whole layer is finished.
  assign y_last     = (y  == YW'(FEATURE_MAP_HEIGHT - 1));
  assign x_last     = (x  == XW'(FEATURE_MAP_WIDTH - 1));
  assign co_last    = (co == COW'(OUTPUT_NB_CHANNELS - 1));
  assign ci_last    = (ci == CIW'(INPUT_NB_CHANNELS - 1));
  assign ky_last    = (ky == KW'(KERNEL_SIZE - 1));
  assign layer_done = y_last && x_last && co_last && ci_last;

  // A row moves only when both operands are present. This keeps a and b rows paired.
  assign transfer = a_valid && b_valid;

  // Partial-sum slot for the current output pixel and output channel. The sum is
  // formed at 64 bits and then truncated to the memory address width.
  assign addr = AW'((64'(y) * 64'(FEATURE_MAP_WIDTH) + 64'(x)) * 64'(OUTPUT_NB_CHANNELS)
                    + 64'(co));

  // Coordinates of the output being produced. They follow the counters directly.
  assign output_x  = x;
  assign output_y  = y;
  assign output_ch = co;

  // State register and loop counters. rst_in takes priority, even in the middle of a layer.
  // NOTE: sequential state uses non-blocking assignments, so every register samples
  // the values from before the clock edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state <= IDLE;
      y     <= '0;
      x     <= '0;
      co    <= '0;
      ci    <= '0;
      ky    <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (start) begin
            y  <= '0;
            x  <= '0;
            co <= '0;
            ci <= '0;
            ky <= '0;
          end
        end
        MAC: begin
          if (!ky_last) begin
            ky <= ky + KW'(1);
          end
        end
        WRITE: begin
          ky <= '0;
          if (!ci_last) begin
            ci <= ci + CIW'(1);
          end else begin
            ci <= '0;
            if (!co_last) begin
              co <= co + COW'(1);
            end else begin
              co <= '0;
              if (!x_last) begin
                x <= x + XW'(1);
              end else begin
                x <= '0;
                if (!y_last) begin
                  y <= y + YW'(1);
                end else begin
                  y <= '0;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and all control outputs. The outputs depend only on the state and
  // counters, plus the valid pair while in FETCH.
  // NOTE: every output gets a default before the case statement, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next              = state;
    running                 = 1'b0;
    a_ready                 = 1'b0;
    b_ready                 = 1'b0;
    write_a                 = 1'b0;
    write_b                 = 1'b0;
    mac_valid               = 1'b0;
    mac_accumulate_internal = 1'b0;
    mac_accumulate_with_0   = 1'b0;
    mem_re                  = 1'b0;
    mem_read_addr           = '0;
    mem_we                  = 1'b0;
    mem_write_addr          = '0;
    output_valid            = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
        end
      end

      FETCH: begin
        running       = 1'b1;
        a_ready       = transfer;
        b_ready       = transfer;
        write_a       = transfer;
        write_b       = transfer;
        // The first kernel row of every input channel after the first one needs the
        // stored partial sum. The memory has a 1-cycle read latency, so that sum
        // arrives just as the MAC cycle takes it.
        mem_re        = (ky == '0) && (ci != '0);
        mem_read_addr = addr;
        if (transfer) begin
          state_next = MAC;
        end
      end

      MAC: begin
        running                 = 1'b1;
        mac_valid               = 1'b1;
        mac_accumulate_internal = (ky != '0);
        mac_accumulate_with_0   = (ky == '0) && (ci == '0);
        mem_read_addr           = addr;
        state_next              = ky_last ? WRITE : FETCH;
      end

      WRITE: begin
        // The mac3 output register holds the finished kernel sum for this channel.
        running        = 1'b1;
        mem_we         = 1'b1;
        mem_write_addr = addr;
        mem_read_addr  = addr;
        output_valid   = ci_last;
        state_next     = layer_done ? IDLE : FETCH;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Testbench for conv_loop_sequencer.
// The reference model walks the layer with plain nested loops and queues the MAC and
// WRITE events it expects. A monitor running on the falling clock edge pops and compares
// an event each time the DUT presents one.
module tb_conv_loop_sequencer;

  localparam int AW   = 3;   // small, so that address truncation is exercised
  localparam int W    = 3;
  localparam int H    = 2;
  localparam int CI   = 3;
  localparam int CO   = 2;
  localparam int K    = 3;
  localparam int XW   = $clog2(W);
  localparam int YW   = $clog2(H);
  localparam int CW   = $clog2(CO);
  localparam int NSTEP = W * H * CO * CI;
  localparam int OUTW = 11 + 2 * AW + XW + YW + CW;

  logic clk = 1'b0;
  logic rst_in, start, a_valid, b_valid;
  logic running, a_ready, b_ready, write_a, write_b, mac_valid;
  logic mac_accumulate_internal, mac_accumulate_with_0;
  logic mem_re, mem_we, output_valid;
  logic [AW-1:0] mem_read_addr, mem_write_addr;
  logic [XW-1:0] output_x;
  logic [YW-1:0] output_y;
  logic [CW-1:0] output_ch;

  conv_loop_sequencer #(
    .LOG2_OF_MEM_HEIGHT(AW),
    .FEATURE_MAP_WIDTH (W),
    .FEATURE_MAP_HEIGHT(H),
    .INPUT_NB_CHANNELS (CI),
    .OUTPUT_NB_CHANNELS(CO),
    .KERNEL_SIZE       (K)
  ) dut (
    .clk                    (clk),
    .rst_in                 (rst_in),
    .start                  (start),
    .running                (running),
    .a_valid                (a_valid),
    .b_valid                (b_valid),
    .a_ready                (a_ready),
    .b_ready                (b_ready),
    .write_a                (write_a),
    .write_b                (write_b),
    .mac_valid              (mac_valid),
    .mac_accumulate_internal(mac_accumulate_internal),
    .mac_accumulate_with_0  (mac_accumulate_with_0),
    .mem_re                 (mem_re),
    .mem_read_addr          (mem_read_addr),
    .mem_we                 (mem_we),
    .mem_write_addr         (mem_write_addr),
    .output_valid           (output_valid),
    .output_x               (output_x),
    .output_y               (output_y),
    .output_ch              (output_ch)
  );

  always #5 clk = ~clk;

  logic [OUTW-1:0] all_out;
  assign all_out = {running, a_ready, b_ready, write_a, write_b, mac_valid,
                    mac_accumulate_internal, mac_accumulate_with_0, mem_re, mem_read_addr,
                    mem_we, mem_write_addr, output_valid, output_x, output_y, output_ch};

  typedef struct {
    bit          internal;
    bit          with_0;
    bit          need_read;
    int unsigned addr;
  } mac_exp_t;

  typedef struct {
    int unsigned addr;
    bit          last_ci;
    int unsigned x;
    int unsigned y;
    int unsigned ch;
  } wr_exp_t;

  mac_exp_t mac_q[$];
  wr_exp_t  wr_q[$];
  mac_exp_t m_cur;
  wr_exp_t  w_cur;

  int n_cmp = 0;
  int n_bad = 0;
  int run_cycles = 0;
  bit rand_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the whole layer, in loop order, as a list of expected events.
  function automatic void load_layer();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        for (int cc = 0; cc < CO; cc++)
          for (int ii = 0; ii < CI; ii++) begin
            int unsigned a;
            a = ((yy * W + xx) * CO + cc) % (1 << AW);
            for (int kk = 0; kk < K; kk++)
              mac_q.push_back('{kk != 0, (kk == 0) && (ii == 0), (kk == 0) && (ii != 0), a});
            wr_q.push_back('{a, ii == CI - 1, xx, yy, cc});
          end
  endfunction

  // One cycle of stimulus. Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_valid) begin
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_done(input int bound, input string name);
    int n = 0;
    while (running !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    check(name, n < bound, 1);
  endtask

  task automatic start_layer();
    check("running_low_before_start", running, 0);
    load_layer();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("running_after_start", running, 1);
  endtask

  // Monitor: checks invariants on every cycle, and compares against the scoreboard
  // whenever the DUT presents a MAC or a WRITE.
  logic prev_xfer, prev_re;
  logic [AW-1:0] prev_raddr;

  always @(negedge clk) begin
    if (rst_in) begin
      prev_xfer  <= 1'b0;
      prev_re    <= 1'b0;
      prev_raddr <= '0;
    end else begin
      if (running) run_cycles <= run_cycles + 1;
      if (!running) check("idle_outputs_zero", all_out, 0);
      check("re_we_exclusive", mem_re & mem_we, 0);
      if (a_ready | b_ready | write_a | write_b) begin
        check("handshake_group", {a_ready, b_ready, write_a, write_b}, 4'hf);
        check("ready_needs_both_valid", a_valid & b_valid, 1);
      end
      if (!mac_valid)
        check("acc_flags_outside_mac", {mac_accumulate_internal, mac_accumulate_with_0}, 0);

      if (mac_valid) begin
        if (mac_q.size() == 0) begin
          check("unexpected_mac", mac_valid, 0);
        end else begin
          m_cur = mac_q.pop_front();
          check("mac_after_transfer", prev_xfer, 1);
          check("mac_internal", mac_accumulate_internal, m_cur.internal);
          check("mac_with_0", mac_accumulate_with_0, m_cur.with_0);
          check("mem_re_before_mac", prev_re, m_cur.need_read);
          if (m_cur.need_read) check("mem_read_addr", prev_raddr, m_cur.addr);
          check("mem_re_during_mac", mem_re, 0);
        end
      end

      if (mem_we | output_valid) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", mem_we | output_valid, 0);
        end else begin
          w_cur = wr_q.pop_front();
          check("write_we", mem_we, 1);
          check("mem_write_addr", mem_write_addr, w_cur.addr);
          check("output_valid", output_valid, w_cur.last_ci);
          if (w_cur.last_ci) begin
            check("output_x", output_x, w_cur.x);
            check("output_y", output_y, w_cur.y);
            check("output_ch", output_ch, w_cur.ch);
          end
        end
      end

      prev_xfer  <= a_ready;
      prev_re    <= mem_re;
      prev_raddr <= mem_read_addr;
    end
  end

  initial begin
    int base;
    rst_in  = 1'b1;
    start   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    tick();
    check("reset_outputs_zero", all_out, 0);
    rst_in = 1'b0;
    tick();

    // Layer 1: both valids held high. A start pulse mid-layer must be ignored,
    // so the layer takes exactly 7 cycles per step.
    a_valid = 1'b1;
    b_valid = 1'b1;
    base = run_cycles;
    start_layer();
    repeat (100) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(4000, "layer1_timeout");
    check("layer1_run_cycles", run_cycles - base, 7 * NSTEP);
    check("layer1_mac_q_drained", mac_q.size(), 0);
    check("layer1_wr_q_drained", wr_q.size(), 0);

    // Layer 2: random valids, plus a directed stall with only a_valid high.
    rand_valid = 1'b1;
    base = run_cycles;
    start_layer();
    repeat (40) tick();
    rand_valid = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b0;
    repeat (5) tick();
    b_valid = 1'b1;
    rand_valid = 1'b1;
    wait_done(8000, "layer2_timeout");
    check("layer2_min_cycles", (run_cycles - base) >= 7 * NSTEP, 1);
    check("layer2_mac_q_drained", mac_q.size(), 0);
    check("layer2_wr_q_drained", wr_q.size(), 0);

    // Layer 3: reset held for 2 cycles mid-layer. The DUT must drop to IDLE.
    start_layer();
    repeat (150) tick();
    rst_in = 1'b1;
    tick();
    tick();
    check("midreset_outputs_zero", all_out, 0);
    mac_q.delete();
    wr_q.delete();
    rst_in = 1'b0;
    tick();
    check("after_reset_idle", all_out, 0);

    // Layer 4: a clean full-speed run after the reset.
    rand_valid = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    base = run_cycles;
    start_layer();
    wait_done(4000, "layer4_timeout");
    check("layer4_run_cycles", run_cycles - base, 7 * NSTEP);
    check("layer4_mac_q_drained", mac_q.size(), 0);
    check("layer4_wr_q_drained", wr_q.size(), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
